// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream_demux packet demultiplexer.
package stream_demux_pkg;

  typedef enum logic {ST_IDLE, ST_PKT} demux_state_t;

  // True when a destination index does not name an existing output channel.
  function automatic logic sel_out_of_range(input int unsigned sel, input int unsigned n_out);
    return sel >= n_out;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Valid/ready bundle for stream_demux: one input stream, N_OUT output channels sharing data/last.
interface stream_demux_if #(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = $clog2(N_OUT);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic [SEL_W-1:0]  s_sel;
  logic [N_OUT-1:0]  m_valid;
  logic [N_OUT-1:0]  m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output s_valid, s_data, s_last, s_sel, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, s_sel, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/stream_demux_reg.sv
// One-entry valid/ready register slice holding data, last flag and destination route.
module stream_demux_reg #(
  parameter int DATA_W  = 8,
  parameter int ROUTE_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [ROUTE_W-1:0] in_route,
  input  logic               out_ready,
  output logic               full,
  output logic [ROUTE_W-1:0] hold_route,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last
);

  // Reload while draining keeps full set, giving one beat per cycle.
  assign in_ready = !full || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full       <= 1'b0;
      hold_route <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else if (in_valid && in_ready) begin
      full       <= 1'b1;
      hold_route <= in_route;
      out_data   <= in_data;
      out_last   <= in_last;
    end else if (out_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N packet demultiplexer with per-packet route lock and one registered output stage.
// Define STREAM_DEMUX_DROP_OOR_EN to discard packets whose first-beat s_sel is out of range.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    bus,
  output logic             busy,
  output logic             err_sel
);
  localparam int SEL_W = $clog2(N_OUT);

  demux_state_t      state;
  logic [SEL_W-1:0]  route_q;
  logic [SEL_W-1:0]  cur_route;
  logic [SEL_W-1:0]  hold_route;
  logic              first_beat;
  logic              sel_oor;
  logic              cur_drop;
  logic              accept;
  logic              full;
  logic              held_ready;
  logic              slice_ready;
  logic [N_OUT-1:0]  m_valid_d;
`ifdef STREAM_DEMUX_DROP_OOR_EN
  logic              drop_q;
`endif

  always_comb begin
    first_beat = (state == ST_IDLE);
    sel_oor    = sel_out_of_range(32'(bus.s_sel), N_OUT);
    cur_route  = first_beat ? bus.s_sel : route_q;
`ifdef STREAM_DEMUX_DROP_OOR_EN
    cur_drop   = first_beat ? sel_oor : drop_q;
`else
    cur_drop   = 1'b0;
    if (first_beat && sel_oor) cur_route = '0;
`endif
  end

  // Only the held beat's channel ready matters; other channels cannot bypass it.
  always_comb begin
    held_ready = 1'b0;
    m_valid_d  = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (hold_route == SEL_W'(i)) begin
        held_ready   = bus.m_ready[i];
        m_valid_d[i] = full;
      end
    end
  end

  assign bus.s_ready = rst_n && (cur_drop || slice_ready);
  assign bus.m_valid = rst_n ? m_valid_d : '0;
  assign accept      = bus.s_valid && bus.s_ready;

  stream_demux_reg #(
    .DATA_W  (DATA_W),
    .ROUTE_W (SEL_W)
  ) u_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (bus.s_valid && rst_n && !cur_drop),
    .in_ready   (slice_ready),
    .in_data    (bus.s_data),
    .in_last    (bus.s_last),
    .in_route   (cur_route),
    .out_ready  (held_ready),
    .full       (full),
    .hold_route (hold_route),
    .out_data   (bus.m_data),
    .out_last   (bus.m_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      route_q <= '0;
      busy    <= 1'b0;
      err_sel <= 1'b0;
`ifdef STREAM_DEMUX_DROP_OOR_EN
      drop_q  <= 1'b0;
`endif
    end else begin
      err_sel <= accept && first_beat && sel_oor;
      if (accept) begin
        if (bus.s_last) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
`ifdef STREAM_DEMUX_DROP_OOR_EN
          drop_q <= 1'b0;
`endif
        end else if (first_beat) begin
          state   <= ST_PKT;
          busy    <= 1'b1;
          route_q <= cur_route;
`ifdef STREAM_DEMUX_DROP_OOR_EN
          drop_q  <= sel_oor;
`endif
        end
      end
    end
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1-to-N packet demultiplexer for valid/ready byte streams; the routing counterpart of the 2:1 selector used on the merge side of the datapath.
- The route is taken from s_sel on the first beat of each packet and locked until the beat carrying s_last is accepted.
- One registered output stage gives 1-cycle latency at full throughput.

Parameters:
- N_OUT, 4, number of output channels (2..16; need not be a power of two).
- DATA_W, 8, data width in bits.
- SEL_W, $clog2(N_OUT), width of s_sel; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid && s_ready.
- s_data  input  DATA_W  input beat data.
- s_last  input  1  last beat of the packet.
- s_sel  input  SEL_W  destination channel; sampled only on a packet's first beat.
- m_valid  output  N_OUT  one-hot valid; at most one bit set.
- m_ready  input  N_OUT  per-channel ready.
- m_data  output  DATA_W  shared output data, qualified by m_valid.
- m_last  output  1  shared last flag, qualified by m_valid.
- busy  output  1  high while a packet is open (state PKT).
- err_sel  output  1  one-cycle pulse when an out-of-range s_sel is sampled.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state is sampled on the rising edge while rst_n=0.
- Reset values: state=IDLE, full=0, route=0, m_valid=0, m_data=0, m_last=0, busy=0, err_sel=0.
- s_ready is 0 while rst_n=0.
- Reset mid-packet discards the held beat and the open packet. No output handshake completes in the reset cycle.
- Route selection per accepted beat:
  - IDLE: cur_route = s_sel.
  - PKT: cur_route = route_q (s_sel ignored).
- FSM IDLE -> PKT: on an accepted beat with s_last=0; route_q <= s_sel.
- FSM PKT -> IDLE: on an accepted beat with s_last=1.
- A single-beat packet (s_last=1 in IDLE) stays in IDLE.
- Output register:
  - full: one held beat with hold_route.
  - m_valid[i] = full && (hold_route==i).
  - m_data and m_last are driven from the register; they hold their last value when full=0.
- Handshake:
  - s_ready = !full || m_ready[hold_route]. Combinational from m_ready only; no dependency on s_valid.
  - Simultaneous drain and fill: the register reloads in the same cycle, so full stays 1. This gives 1 beat/cycle.
  - Drain only: full <= 0. Fill only: full <= 1.
- Latency: an accepted beat appears on m_* on the next cycle.
- Blocking: m_valid/m_data/m_last are held stable while m_ready[hold_route]=0. Ready on non-selected channels is ignored, with no head-of-line bypass.
- Out-of-range s_sel (s_sel >= N_OUT, sampled in IDLE):
  - err_sel pulses for 1 cycle after acceptance.
  - Routing follows the optional-feature rules below.
  - s_sel is ignored in PKT, so it is never checked there.
- busy = (state==PKT).

Optional Feature:
- Macro: STREAM_DEMUX_DROP_OOR_EN.
- Defined: a packet whose first-beat s_sel is out of range is accepted and discarded.
  - s_ready = 1 for all its beats regardless of m_ready.
  - No m_valid is raised for it.
  - An internal drop flag is held until the s_last beat is accepted.
  - A beat already in the output register still drains normally.
- Undefined: an out-of-range packet is routed to channel 0 with normal backpressure.
- err_sel pulses in both builds.

Decomposition:
- Package stream_demux_pkg holds:
  - typedef enum logic {ST_IDLE, ST_PKT} demux_state_t.
  - Function for sel-range check.
- Sub-module stream_demux_reg: a one-entry valid/ready register slice (data+last+route) that owns full and hold_route.
- The top owns the FSM, route lock, drop logic, and the one-hot decode of m_valid.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with s_valid=1 -> s_ready=0, m_valid=0, m_data=0. Release reset -> s_ready=1.
- Single beat: s_sel=2, s_data=0xA5, s_last=1 -> next cycle m_valid=4'b0100, m_data=0xA5, m_last=1. busy stays 0.
- Route lock: 3-beat packet (0x11, 0x22, 0x33) with s_sel=1 on the first beat, then s_sel=3 on beats 2-3:
  - All 3 beats exit on channel 1 (m_valid=4'b0010) at 1 beat/cycle.
  - busy=1 for cycles 2-3.
- Backpressure: m_ready[1]=0 for 3 cycles mid-packet:
  - s_ready=0 after one beat is held; m_data stays stable.
  - m_ready[0,2,3]=1 has no effect; on release, no beat is lost or duplicated.
- Back-to-back packets: 2-beat packet to channel 0, then in the very next cycle a 1-beat packet to channel 3 -> m_valid goes 0001, 0001, 1000 on consecutive cycles.
- Out of range with N_OUT=3, s_sel=3, 2-beat packet:
  - err_sel pulses once in both builds.
  - With STREAM_DEMUX_DROP_OOR_EN defined: s_ready=1 with m_ready=0, m_valid stays 0.
  - Without the macro: both beats appear on m_valid=3'b001.
